// File: rtl/aes_pkg.sv
// Shared AES constants, state type and byte-index helper.
package aes_pkg;

  localparam int unsigned AES_NB          = 4;
  localparam int unsigned AES_BLOCK_BYTES = 16;

  // Packed state: slot j holds byte k = AES_BLOCK_BYTES-1-j, so byte 0 sits in bits [127:120].
  typedef logic [AES_BLOCK_BYTES-1:0][7:0] aes_state_t;

  // Column-major byte index of s[r][c].
  function automatic int unsigned aes_byte_idx(input int unsigned r, input int unsigned c);
    return AES_NB * c + r;
  endfunction

endpackage

// File: rtl/shiftrows_fwd.sv
// Purely combinational forward ShiftRows: s'[r][c] = s[r][(c + r) mod 4].
module shiftrows_fwd
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);

  aes_state_t din_s;
  aes_state_t dout_s;

  assign din_s = din;
  assign dout  = dout_s;

  // Static byte permutation; loops unroll to wiring only.
  always_comb begin
    dout_s = '0;
    for (int unsigned r = 0; r < AES_NB; r++) begin
      for (int unsigned c = 0; c < AES_NB; c++) begin
        dout_s[4'(AES_BLOCK_BYTES - 1 - aes_byte_idx(r, c))] =
            din_s[4'(AES_BLOCK_BYTES - 1 - aes_byte_idx(r, (c + r) % AES_NB))];
      end
    end
  end

endmodule

// File: rtl/shiftrows_serial.sv
// Byte-serial loader into a ping-pong bank pair, emitting each full block with forward
// ShiftRows applied on a 128-bit valid/ready output. Blocks leave in arrival order.
module shiftrows_serial
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  logic       resetn_q;
  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [3:0] fill_cnt_q, fill_cnt_d;

  aes_state_t   bank0_q, bank1_q;
  aes_state_t   rd_bank;
  logic [127:0] shifted;

  logic in_fire;
  logic out_fire;
  logic last_byte;

  // in_ready is built only from registers, so out_ready never reaches it combinationally.
  assign in_ready  = resetn_q & ~full_q[wr_sel_q];
  // A byte arriving together with abort is dropped.
  assign in_fire   = in_valid & in_ready & ~abort;
  assign last_byte = (fill_cnt_q == 4'(AES_BLOCK_BYTES - 1));
  assign out_valid = full_q[rd_sel_q];
  assign out_fire  = out_valid & out_ready;
  assign busy      = (|full_q) | (fill_cnt_q != 4'd0);

  assign rd_bank   = rd_sel_q ? bank1_q : bank0_q;

  shiftrows_fwd u_shiftrows_fwd (
    .din  (rd_bank),
    .dout (shifted)
  );

  assign out_block = out_valid ? shifted : 128'h0;

  // Next-state for flags, selects and fill counter; fill and drain touch different banks.
  always_comb begin
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    fill_cnt_d = fill_cnt_q;

    if (abort) begin
      fill_cnt_d = 4'd0;
    end else if (in_fire) begin
      fill_cnt_d = fill_cnt_q + 4'd1;
      if (last_byte) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end
    end

    if (out_fire) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      resetn_q   <= 1'b0;
      full_q     <= 2'b00;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      fill_cnt_q <= 4'd0;
    end else begin
      resetn_q   <= 1'b1;
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Bank data is not reset; ~fill_cnt_q maps byte k onto packed slot 15-k.
  always_ff @(posedge clk) begin
    if (in_fire && !wr_sel_q) begin
      bank0_q[~fill_cnt_q] <= in_byte;
    end
    if (in_fire && wr_sel_q) begin
      bank1_q[~fill_cnt_q] <= in_byte;
    end
  end

endmodule

// File: tb/tb_shiftrows_serial.sv
// Directed self-checking bench for shiftrows_serial.
module tb_shiftrows_serial;

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;

  int n_cmp;
  int n_err;

  localparam logic [127:0] ID_IN    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ID_OUT   = 128'h00050a0f_04090e03_080d0207_0c01060b;
  localparam logic [127:0] A_IN     = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] A_OUT    = 128'h10151a1f_14191e13_181d1217_1c11161b;
  localparam logic [127:0] B_IN     = 128'h202122232425262728292a2b2c2d2e2f;
  localparam logic [127:0] B_OUT    = 128'h20252a2f_24292e23_282d2227_2c21262b;
  localparam logic [127:0] FIPS_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

  shiftrows_serial dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one byte and hold it until accepted; ends 1 time unit after the accepting edge.
  task automatic push_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: in_ready got %b want 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Push bytes first..last of a block (byte k at bits [127-8k -: 8]).
  task automatic push_range(input logic [127:0] blk, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      push_byte(8'(blk >> (8 * (15 - k))));
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b1; in_byte = 8'haa; abort = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (out_block !== 128'h0) begin n_err++; $display("FAIL rst_out_block: got %h want 0", out_block); end
    resetn = 1'b1; in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_release_in_ready: got %b want 0", in_ready); end
    step(); step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready_up: got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_identity();
    out_ready = 1'b1;
    push_range(ID_IN, 0, 14);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL id_early_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL id_busy_partial: got %b want 1", busy); end
    push_range(ID_IN, 15, 15);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL id_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_block !== ID_OUT) begin n_err++; $display("FAIL id_block: got %h want %h", out_block, ID_OUT); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL id_one_cycle: got %b want 0", out_valid); end
    n_cmp++; if (out_block !== 128'h0) begin n_err++; $display("FAIL id_block_idle: got %h want 0", out_block); end
  endtask

  task automatic test_fips();
    out_ready = 1'b1;
    push_range(FIPS_IN, 0, 15);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fips_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_block !== FIPS_OUT) begin n_err++; $display("FAIL fips_block: got %h want %h", out_block, FIPS_OUT); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_range(ID_IN, 0, 15);
    push_range(A_IN, 0, 15);
    in_valid = 1'b1; in_byte = 8'h20;
    repeat (4) step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
    n_cmp++; if (out_block !== ID_OUT) begin n_err++; $display("FAIL bp_first_held: got %h want %h", out_block, ID_OUT); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_block !== A_OUT) begin n_err++; $display("FAIL bp_second: got %h want %h", out_block, A_OUT); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_free: got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    push_range(B_IN, 0, 15);
    n_cmp++; if (out_block !== B_OUT) begin n_err++; $display("FAIL bp_third: got %h want %h", out_block, B_OUT); end
    step();
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) push_byte(8'h55 + 8'(k));
    in_valid = 1'b1; in_byte = 8'h77; abort = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_fill_cleared: busy got %b want 0", busy); end
    push_range(FIPS_IN, 0, 15);
    n_cmp++; if (out_block !== FIPS_OUT) begin n_err++; $display("FAIL abort_block: got %h want %h", out_block, FIPS_OUT); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_extra: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    push_range(ID_IN, 0, 15);
    push_range(A_IN, 0, 14);
    n_cmp++; if (out_block !== ID_OUT) begin n_err++; $display("FAIL b2b_first: got %h want %h", out_block, ID_OUT); end
    out_ready = 1'b1;
    push_range(A_IN, 15, 15);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_block !== A_OUT) begin n_err++; $display("FAIL b2b_second: got %h want %h", out_block, A_OUT); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    push_range(ID_IN, 0, 15);
    push_range(A_IN, 0, 8);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mr_busy_before: got %b want 1", busy); end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mr_busy: got %b want 0", busy); end
    n_cmp++; if (out_block !== 128'h0) begin n_err++; $display("FAIL mr_out_block: got %h want 0", out_block); end
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_out_valid_later: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mr_in_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    resetn = 1'b0; in_valid = 1'b0; in_byte = 8'h00; abort = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_identity();
    test_fips();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
